// File: rtl/addsub_pkg.sv
// Shared definitions for the multicycle add/subtract unit: mode codes,
// FSM state encoding and a counter-width helper.
package addsub_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ADC = 2'b10;
    localparam logic [1:0] MODE_SBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Chunk counter width: clog2 of the chunk count, never narrower than one bit.
    function automatic int cnt_width(input int nch);
        int w;
        if (nch > 1) begin
            w = $clog2(nch);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/addsub_multicycle_chunk.sv
// Combinational CHUNK-bit ripple adder slice; cmsb is the carry entering the
// top bit so the caller can derive signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin
);

    // Bitwise ripple through the slice, capturing the carry into the MSB.
    always_comb begin
        logic w_c;
        w_c  = cin;
        cmsb = cin;
        sum  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cmsb   = (i == CHUNK - 1) ? w_c : cmsb;
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (a[i] & w_c) | (b[i] & w_c);
        end
        cout = w_c;
    end

endmodule

// File: rtl/addsub_multicycle.sv
// WIDTH-bit add/subtract unit that walks CHUNK bits per clock through a
// single ripple slice, with N/Z/C/V flags and a persistent carry for ADC/SBC.
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       M,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [CW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cflag;
    logic             w_cin;
    logic             w_last;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_n;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;

    assign w_last = (r_idx == LAST_IDX);

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb),
        .a    (r_a[r_idx*CHUNK +: CHUNK]),
        .b    (r_b[r_idx*CHUNK +: CHUNK]),
        .cin  (r_carry)
    );

    // Initial carry-in selected by the incoming mode.
    always_comb begin
        w_cin = 1'b0;
        case (M)
            MODE_ADD: w_cin = 1'b0;
            MODE_SUB: w_cin = 1'b1;
            MODE_ADC: w_cin = r_cflag;
            MODE_SBC: w_cin = r_cflag;
            default:  w_cin = 1'b0;
        endcase
    end

    // Shadow result with the current slice merged in.
    always_comb begin
        w_sh_nxt = r_sh;
        w_sh_nxt[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_RUN:  in_ready  = 1'b0;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture, slice sequencing and flag update on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cflag <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= M[0] ? ~B : B;
                        r_carry <= w_cin;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sh    <= w_sh_nxt;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + CW'(1);
                    if (w_last) begin
                        r_s     <= w_sh_nxt;
                        r_c     <= w_cout;
                        r_v     <= w_cout ^ w_cmsb;
                        r_z     <= (w_sh_nxt == '0);
                        r_n     <= w_sh_nxt[WIDTH-1];
                        r_cflag <= w_cout;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign S = r_s;
    assign C = r_c;
    assign V = r_v;
    assign Z = r_z;
    assign N = r_n;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed scoreboard bench for addsub_multicycle (16/4 build plus a
// single-pass 16/16 build).
module tb_addsub_multicycle;
    import addsub_pkg::*;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] A, B, S;
    logic [1:0]  M;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        C, V, Z, N;

    logic [15:0] A16, B16, S16;
    logic [1:0]  M16;
    logic        iv16, ir16, ov16, C16, V16, Z16, N16;

    exp_t q[$];
    logic cflag_m;
    int   checks;
    int   errors;

    addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .M(M),
        .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .C(C), .V(V), .Z(Z), .N(N),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    addsub_multicycle #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .A(A16), .B(B16), .M(M16),
        .in_valid(iv16), .in_ready(ir16),
        .S(S16), .C(C16), .V(V16), .Z(Z16), .N(N16),
        .out_valid(ov16), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: wide addition of the effective operands.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
        logic [15:0] bb;
        logic        cin;
        logic [16:0] r;
        exp_t        e;
        bb = m[0] ? ~b : b;
        case (m)
            MODE_ADD: cin = 1'b0;
            MODE_SUB: cin = 1'b1;
            default:  cin = cflag_m;
        endcase
        r   = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
        e.s = r[15:0];
        e.c = r[16];
        e.v = (a[15] == bb[15]) && (r[15] != a[15]);
        e.z = (r[15:0] == 16'd0);
        e.n = r[15];
        cflag_m = e.c;
        q.push_back(e);
    endtask

    // Present an operation and return #1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input bit do_push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        A = a; B = b; M = m; in_valid = 1'b1;
        if (do_push) push_exp(a, b, m);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and pop/compare the scoreboard.
    task automatic wait_result(input int exp_lat, input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_qsize"}, 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_S"}, 32'(S), 32'(e.s));
            chk({tag, "_CVZN"}, 32'({C, V, Z, N}), 32'({e.c, e.v, e.z, e.n}));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cflag_m = 1'b0;
        rst_n = 1'b0; A = '0; B = '0; M = '0; in_valid = 1'b0; out_ready = 1'b0;
        A16 = '0; B16 = '0; M16 = '0; iv16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_flags", 32'({C, V, Z, N}), 32'd0);

        send(16'h7FFF, 16'h0001, MODE_ADD, 1'b1);
        wait_result(4, "add_ovf");
        release_out("add_ovf");

        send(16'h0005, 16'h0005, MODE_SUB, 1'b1);
        wait_result(4, "sub_eq");
        release_out("sub_eq");

        send(16'h0003, 16'h0005, MODE_SUB, 1'b1);
        wait_result(4, "sub_neg");
        release_out("sub_neg");

        send(16'hFFFF, 16'h0001, MODE_ADD, 1'b1);
        wait_result(4, "chain_lo");
        release_out("chain_lo");
        send(16'h0000, 16'h0000, MODE_ADC, 1'b1);
        wait_result(4, "chain_hi");
        release_out("chain_hi");

        send(16'h0000, 16'h0001, MODE_SUB, 1'b1);
        wait_result(4, "sbc_lo");
        release_out("sbc_lo");
        send(16'h0001, 16'h0000, MODE_SBC, 1'b1);
        wait_result(4, "sbc_hi");
        release_out("sbc_hi");

        // Backpressure: hold the result while a new request waits.
        send(16'h1111, 16'h2222, MODE_ADD, 1'b1);
        wait_result(4, "bp_first");
        A = 16'h8000; B = 16'h8000; M = MODE_ADD; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_ov_hold", 32'(out_valid), 32'd1);
            chk("bp_ir_low", 32'(in_ready), 32'd0);
            chk("bp_S_hold", 32'(S), 32'h3333);
        end
        release_out("bp_release");
        push_exp(16'h8000, 16'h8000, MODE_ADD);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        wait_result(4, "bp_second");
        release_out("bp_second");

        // Reset in the middle of a run after cflag was left set.
        send(16'hFFFF, 16'h0002, MODE_ADD, 1'b1);
        wait_result(4, "pre_rst");
        release_out("pre_rst");
        send(16'hFFFF, 16'h0001, MODE_ADD, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cflag_m = 1'b0;
        q.delete();
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_S", 32'(S), 32'd0);
        chk("mid_rst_flags", 32'({C, V, Z, N}), 32'd0);
        chk("mid_rst_ir", 32'(in_ready), 32'd1);
        send(16'h0001, 16'h0001, MODE_ADC, 1'b1);
        wait_result(4, "adc_after_rst");
        release_out("adc_after_rst");

        // Single-pass build.
        @(negedge clk);
        A16 = 16'h1234; B16 = 16'h4321; M16 = MODE_ADD; iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        chk("c16_not_yet", 32'(ov16), 32'd0);
        @(posedge clk);
        #1;
        chk("c16_ov", 32'(ov16), 32'd1);
        chk("c16_S", 32'(S16), 32'h5555);
        chk("c16_flags", 32'({C16, V16, Z16, N16}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
